oqpsk_mod: RTL and testbench
============================

# oqpsk_mod

Transmit-side O-QPSK modulator for the Zigbee IQ path, the counterpart of the `iq_demod` receive chain. It accepts a serial chip stream through a valid/ready handshake and routes even chips to I and odd chips to Q. Each chip is shaped with a half-sine pulse, with Q offset by one chip period. It emits 5-bit signed I/Q sample pairs at a fixed sample cadence, in the same `sample_t` format and quantum (0.03226 per LSB) that the demodulator filters consume.

## Interface

Parameters:

- `SPC`, 4: samples per chip period Tc. One rail pulse lasts 2·SPC samples.
- `CLK_DIV`, 5: clock cycles per output sample while running. Must be ≥ 2.
- `AMP`, 15: peak pulse magnitude in LSBs. Must be ≤ 15.

Ports:

- `clk`, in, 1: single system clock.
- `resetn`, in, 1: reset, synchronous and active-low.
- `chip_in`, in, 1: chip value. 1 maps to +pulse, 0 maps to −pulse.
- `chip_valid`, in, 1: `chip_in` is valid.
- `chip_ready`, out, 1: a chip is consumed on any cycle where `chip_valid` and `chip_ready` are both high.
- `out_valid`, out, 1: one-cycle strobe marking a new sample pair.
- `i_out`, out, 5: I sample, signed two's complement.
- `q_out`, out, 5: Q sample, signed two's complement.

## Operation

- **State machine:** two states, IDLE and RUN.
- **Per-rail state:** each rail (I, Q) holds `active` and `neg` flags. The rail value is `active ? (neg ? −LUT : +LUT) : 0`.
- **Pulse table:** LUT[n] = round(AMP·sin(π·n/(2·SPC))) for n = 0..2·SPC−1. With the defaults this is 0, 6, 11, 14, 15, 14, 11, 6.
- **Counters:**
  - `s` is the sample index, running 0..2·SPC−1 and wrapping.
  - `div` runs 0..CLK_DIV−1.
  - I uses phase `s`. Q uses phase `(s+SPC) mod 2·SPC`.
- **tick definition:** tick = (RUN ∧ div==CLK_DIV−1) ∨ (IDLE ∧ chip_valid). On every tick:
  - the output registers load the rail values at the current phases;
  - `out_valid` pulses high;
  - `s` increments.
- **Boundaries:** an I boundary is a tick with s==0; a Q boundary is a tick with s==SPC.
- **chip_ready:** combinational, equal to IDLE ∨ (RUN ∧ div==CLK_DIV−1 ∧ (s==0 ∨ s==SPC)).
- **Chip accepted at a boundary:** that rail loads active=1 and neg=~chip_in.
- **No chip at a boundary (underflow):** that rail gets active=0.
- **IDLE → RUN:**
  - taken on chip_valid;
  - the chip loads the I rail with s=0;
  - `div` resets to 0;
  - the Q rail is inactive.
- **RUN → IDLE:**
  - taken at a boundary tick with no chip when the other rail is inactive;
  - that tick still emits its pair, which is (0,0);
  - `s` and `div` return to 0.
- **Arithmetic:** negation uses two's complement of a value ≤ 15, so no overflow is possible. −LUT is never −16.

## Timing

- **Reset values:** `resetn` low at a rising edge forces:
  - IDLE, s=0, div=0;
  - both rails inactive;
  - i_out=0, q_out=0, out_valid=0.
  - `chip_ready` therefore reads 1 the cycle after reset.
- **Reset mid-operation:** aborts immediately, with no flush.
- **First sample:** a chip accepted in IDLE at edge E0 produces its first sample (I=LUT[0]=0) with out_valid high from E0 until the following edge.
- **Sample cadence:** later samples follow every CLK_DIV cycles.
- **out_valid:** high for exactly one cycle per sample and never high in IDLE except on the accepting tick.
- **Chip rate:** in steady state one chip is consumed every SPC samples (SPC·CLK_DIV cycles), alternating I and Q.
- **Output latency:** a rail value is registered one edge after its tick.
- **Simultaneous events:** a boundary tick with chip_valid high always consumes the chip, even on the tick that would otherwise end the burst.

## Structure

- Package `iq_mod_pkg`:
  - `sample_t` (logic signed [4:0]);
  - `QUANTUM` = 0.03226, used by the bench only;
  - state enum {IDLE, RUN}.
- Sub-module `half_sine_lut`:
  - parameters SPC and AMP;
  - combinational phase → magnitude, with the table computed at elaboration;
  - instantiated twice, once for I and once for Q.

## Test plan

All scenarios use defaults: SPC=4, CLK_DIV=5.

1. **Single chip:** one chip 1, then chip_valid low. Expect 9 samples:
   - I = 0, 6, 11, 14, 15, 14, 11, 6, 0;
   - Q = 0 throughout;
   - then IDLE with out_valid low.
2. **Chips 1, 0 back-to-back:** expect 13 samples.
   - I = +pulse for samples 0–7, then 0.
   - Q = 0 for samples 0–3, then 0, −6, −11, −14, −15, −14, −11, −6, then 0 at sample 12.
   - Then IDLE.
3. **Continuous stream 1,1,0,0,1,0…:** chip_ready high every 20 cycles. Per-rail pulses abut with no gap, and the I zero crossings align with Q peaks.
4. **Underflow mid-stream:** drop chip_valid for one I boundary.
   - That I pulse is all zero.
   - The Q pulse completes.
   - Stay in RUN if the next Q chip arrives; otherwise go to IDLE.
5. **Reset mid-burst:** assert resetn low at sample 3. The next edge gives outputs 0, out_valid 0, chip_ready 1, and a fresh burst behaves as in scenario 1.
6. **Loopback:** feed oqpsk_mod outputs into the demod `filter` (I and Q instances). Filter outputs must match the MATLAB `I_out.csv`/`Q_out.csv` within 1 LSB.

Source files
------------

// File: rtl/oqpsk_mod_pkg.sv
// Shared types for the O-QPSK transmit IQ path: sample format, FSM states, rail helper.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package iq_mod_pkg;

  // 5-bit signed sample, same format the demodulator filters consume
  typedef logic signed [4:0] sample_t;

  // Volts-equivalent per LSB, for reporting amplitudes in the bench
  localparam real QUANTUM = 0.03226;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Rail value: zero when inactive, otherwise +/- the pulse magnitude.
  // Magnitude never exceeds 15, so the negation cannot reach -16.
  function automatic sample_t rail_val(input logic act, input logic neg, input logic [3:0] mag);
    sample_t v;
    v = sample_t'({1'b0, mag});
    if (!act) begin
      return '0;
    end
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/oqpsk_mod_if.sv
// Chip input handshake plus I/Q sample output bundle for oqpsk_mod.
// Latency: n/a (wires only).
// Backpressure: chip side is valid/ready; sample side is a one-cycle strobe, no backpressure.
interface oqpsk_mod_if;
  import iq_mod_pkg::*;

  logic    chip_in;
  logic    chip_valid;
  logic    chip_ready;
  logic    out_valid;
  sample_t i_out;
  sample_t q_out;

  // Chip source / sample sink side
  modport master (
    output chip_in, chip_valid,
    input  chip_ready, out_valid, i_out, q_out
  );

  // Modulator side
  modport slave (
    input  chip_in, chip_valid,
    output chip_ready, out_valid, i_out, q_out
  );

endinterface

// File: rtl/oqpsk_mod_half_sine_lut.sv
// Half-sine pulse magnitude table, phase 0..2*SPC-1 -> round(AMP*sin(pi*n/(2*SPC))).
// Latency: combinational; the table is evaluated at elaboration.
// Backpressure: none.
module half_sine_lut #(
  parameter int SPC = 4,
  parameter int AMP = 15,
  localparam int PW = $clog2(2*SPC)
) (
  input  logic [PW-1:0] phase_i,
  output logic [3:0]    mag_o
);

  localparam real PI = 3.14159265358979;

  // Sine by odd Taylor series after folding into [0, pi/2]; plenty accurate for 4-bit output
  function automatic int sine_mag(input int n);
    real x;
    real x2;
    real term;
    real acc;
    x = PI * real'(n) / real'(2*SPC);
    if (x > PI / 2.0) begin
      x = PI - x;
    end
    x2   = x * x;
    term = x;
    acc  = x;
    for (int k = 1; k < 8; k++) begin
      term = -term * x2 / real'((2*k) * (2*k + 1));
      acc  = acc + term;
    end
    return $rtoi(real'(AMP) * acc + 0.5);
  endfunction

  logic [3:0] tbl [2*SPC];

  for (genvar n = 0; n < 2*SPC; n++) begin : g_tbl
    localparam int V = sine_mag(n);
    assign tbl[n] = V[3:0];
  end

  assign mag_o = tbl[phase_i];

endmodule

// File: rtl/oqpsk_mod.sv
// O-QPSK modulator: even chips to I, odd chips to Q, half-sine shaped, Q offset by one chip.
// Latency: sample registered on its tick edge; first pair (0,0-phase) on the accepting edge.
// Backpressure: chip_ready only at rail boundaries while running; output strobe cannot stall.
module oqpsk_mod
  import iq_mod_pkg::*;
#(
  parameter int SPC     = 4,
  parameter int CLK_DIV = 5,
  parameter int AMP     = 15
) (
  input  logic        clk,
  input  logic        resetn,
  oqpsk_mod_if.slave  bus
);

  localparam int SW = $clog2(2*SPC);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [SW-1:0] S_LAST = SW'(2*SPC - 1);
  localparam logic [SW-1:0] S_HALF = SW'(SPC);
  localparam logic [DW-1:0] D_LAST = DW'(CLK_DIV - 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [DW-1:0]   div_q, div_d;
  logic            i_act_q, i_act_d, i_neg_q, i_neg_d;
  logic            q_act_q, q_act_d, q_neg_q, q_neg_d;
  sample_t         i_out_q, i_out_d, q_out_q, q_out_d;
  logic            ov_q, ov_d;

  logic [SW-1:0]   q_phase;
  logic [SW-1:0]   s_next;
  logic [3:0]      i_mag, q_mag;
  logic            div_last, i_bnd, q_bnd, tick;

  assign div_last = (state_q == RUN) && (div_q == D_LAST);
  assign i_bnd    = (s_q == '0);
  assign q_bnd    = (s_q == S_HALF);
  assign tick     = div_last || ((state_q == IDLE) && bus.chip_valid);
  assign s_next   = (s_q == S_LAST) ? '0 : s_q + SW'(1);
  assign q_phase  = (s_q >= S_HALF) ? s_q - S_HALF : s_q + S_HALF;

  assign bus.chip_ready = (state_q == IDLE) || (div_last && (i_bnd || q_bnd));
  assign bus.out_valid  = ov_q;
  assign bus.i_out      = i_out_q;
  assign bus.q_out      = q_out_q;

  half_sine_lut #(.SPC(SPC), .AMP(AMP)) u_lut_i (.phase_i(s_q),     .mag_o(i_mag));
  half_sine_lut #(.SPC(SPC), .AMP(AMP)) u_lut_q (.phase_i(q_phase), .mag_o(q_mag));

  // Next-state: sample emission on tick, chip routing at boundaries, burst start/end
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    div_d   = div_q;
    i_act_d = i_act_q;
    i_neg_d = i_neg_q;
    q_act_d = q_act_q;
    q_neg_d = q_neg_q;
    i_out_d = i_out_q;
    q_out_d = q_out_q;
    ov_d    = 1'b0;

    // Boundary samples sit at phase 0 where the pulse is zero, so the
    // pre-update rail flags give the same value as the post-update ones.
    if (tick) begin
      i_out_d = rail_val(i_act_q, i_neg_q, i_mag);
      q_out_d = rail_val(q_act_q, q_neg_q, q_mag);
      ov_d    = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (bus.chip_valid) begin
          state_d = RUN;
          i_act_d = 1'b1;
          i_neg_d = ~bus.chip_in;
          q_act_d = 1'b0;
          s_d     = s_next;
          div_d   = '0;
        end
      end
      RUN: begin
        if (div_last) begin
          div_d = '0;
          s_d   = s_next;
          if (i_bnd) begin
            if (bus.chip_valid) begin
              i_act_d = 1'b1;
              i_neg_d = ~bus.chip_in;
            end else begin
              i_act_d = 1'b0;
              if (!q_act_q) begin
                state_d = IDLE;
                s_d     = '0;
              end
            end
          end else if (q_bnd) begin
            if (bus.chip_valid) begin
              q_act_d = 1'b1;
              q_neg_d = ~bus.chip_in;
            end else begin
              q_act_d = 1'b0;
              if (!i_act_q) begin
                state_d = IDLE;
                s_d     = '0;
              end
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      s_q     <= '0;
      div_q   <= '0;
      i_act_q <= 1'b0;
      i_neg_q <= 1'b0;
      q_act_q <= 1'b0;
      q_neg_q <= 1'b0;
      i_out_q <= '0;
      q_out_q <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      div_q   <= div_d;
      i_act_q <= i_act_d;
      i_neg_q <= i_neg_d;
      q_act_q <= q_act_d;
      q_neg_q <= q_neg_d;
      i_out_q <= i_out_d;
      q_out_q <= q_out_d;
      ov_q    <= ov_d;
    end
  end

endmodule

// File: tb/tb_oqpsk_mod.sv
// Directed bench for oqpsk_mod with default parameters (SPC=4, CLK_DIV=5, AMP=15).
// Latency: samples captured on the falling edge after each registered tick.
// Backpressure: chip feeder holds valid until the modulator raises ready.
module tb_oqpsk_mod;
  import iq_mod_pkg::*;

  logic clk;
  logic resetn;
  oqpsk_mod_if bus ();

  oqpsk_mod #(.SPC(4), .CLK_DIV(5), .AMP(15)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  // Hand-computed round(15*sin(pi*n/8))
  int PULSE [8] = '{0, 6, 11, 14, 15, 14, 11, 6};

  // Feed entries: 0/1 are chips, 2 holds valid low through one ready cycle
  int      feed [$];
  sample_t got_i [$];
  sample_t got_q [$];
  int      got_t [$];
  int      acc_t [$];
  int      exp_i [$];
  int      exp_q [$];

  // Drive the feed queue for ncyc cycles and capture every output sample
  task automatic run_feed(input int ncyc);
    logic fire;
    got_i.delete();
    got_q.delete();
    got_t.delete();
    acc_t.delete();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        got_i.push_back(bus.i_out);
        got_q.push_back(bus.q_out);
        got_t.push_back(c);
      end
      if (feed.size() > 0 && feed[0] != 2) begin
        bus.chip_valid = 1'b1;
        bus.chip_in    = (feed[0] == 1);
      end else begin
        bus.chip_valid = 1'b0;
        bus.chip_in    = 1'b0;
      end
      #1;
      fire = (bus.chip_ready === 1'b1) && (feed.size() > 0);
      if (fire && feed[0] != 2) acc_t.push_back(c);
      @(posedge clk);
      if (fire) void'(feed.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    resetn         = 1'b0;
    bus.chip_valid = 1'b0;
    bus.chip_in    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.i_out !== 5'sd0) begin failures++; $display("FAIL reset_i got=%0d want=0", bus.i_out); end
    checks++;
    if (bus.q_out !== 5'sd0) begin failures++; $display("FAIL reset_q got=%0d want=0", bus.q_out); end
    checks++;
    if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
    checks++;
    if (bus.chip_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", bus.chip_ready); end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.chip_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset ready=%b valid=%b want ready=1 valid=0", bus.chip_ready, bus.out_valid);
    end
  endtask

  task automatic test_single_chip();
    feed = '{1};
    run_feed(70);
    checks++;
    if (got_i.size() != 9) begin failures++; $display("FAIL single_count got=%0d want=9", got_i.size()); end
    for (int n = 0; n < 9; n++) begin
      int ei;
      ei = (n < 8) ? PULSE[n] : 0;
      checks++;
      if (n >= got_i.size() || int'(got_i[n]) !== ei || int'(got_q[n]) !== 0) begin
        failures++;
        $display("FAIL single_sample n=%0d got I=%0d Q=%0d want I=%0d Q=0", n, got_i[n], got_q[n], ei);
      end
    end
    for (int n = 1; n < got_t.size(); n++) begin
      checks++;
      if (got_t[n] - got_t[n-1] != 5) begin
        failures++;
        $display("FAIL single_cadence n=%0d got=%0d want=5", n, got_t[n] - got_t[n-1]);
      end
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.chip_ready !== 1'b1) begin
      failures++;
      $display("FAIL single_idle valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.chip_ready);
    end
    $display("single chip peak %0d LSB = %f", 15, 15.0 * QUANTUM);
  endtask

  task automatic test_back_to_back();
    feed = '{1, 0};
    run_feed(90);
    exp_i.delete();
    exp_q.delete();
    for (int n = 0; n < 13; n++) begin
      exp_i.push_back((n < 8) ? PULSE[n] : 0);
      exp_q.push_back((n >= 4 && n < 12) ? -PULSE[n-4] : 0);
    end
    checks++;
    if (got_i.size() != 13) begin failures++; $display("FAIL b2b_count got=%0d want=13", got_i.size()); end
    for (int n = 0; n < 13; n++) begin
      checks++;
      if (n >= got_i.size() || int'(got_i[n]) !== exp_i[n] || int'(got_q[n]) !== exp_q[n]) begin
        failures++;
        $display("FAIL b2b_sample n=%0d got I=%0d Q=%0d want I=%0d Q=%0d", n, got_i[n], got_q[n], exp_i[n], exp_q[n]);
      end
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.chip_ready !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.chip_ready);
    end
  endtask

  task automatic test_stream();
    int sgn_i [3] = '{1, -1, 1};
    int sgn_q [3] = '{1, -1, -1};
    feed = '{1, 1, 0, 0, 1, 0};
    run_feed(170);
    exp_i.delete();
    exp_q.delete();
    for (int n = 0; n < 29; n++) begin
      exp_i.push_back((n < 24) ? sgn_i[n/8] * PULSE[n%8] : 0);
      exp_q.push_back((n >= 4 && n < 28) ? sgn_q[(n-4)/8] * PULSE[(n-4)%8] : 0);
    end
    checks++;
    if (got_i.size() != 29) begin failures++; $display("FAIL stream_count got=%0d want=29", got_i.size()); end
    for (int n = 0; n < 29; n++) begin
      checks++;
      if (n >= got_i.size() || int'(got_i[n]) !== exp_i[n] || int'(got_q[n]) !== exp_q[n]) begin
        failures++;
        $display("FAIL stream_sample n=%0d got I=%0d Q=%0d want I=%0d Q=%0d", n, got_i[n], got_q[n], exp_i[n], exp_q[n]);
      end
    end
    // I zero crossings at chip boundaries coincide with full-scale Q
    for (int n = 8; n < 24 && n < got_q.size(); n += 8) begin
      checks++;
      if (got_i[n] !== 5'sd0 || (got_q[n] !== 5'sd15 && got_q[n] !== -5'sd15)) begin
        failures++;
        $display("FAIL stream_align n=%0d got I=%0d Q=%0d want I=0 |Q|=15", n, got_i[n], got_q[n]);
      end
    end
    checks++;
    if (acc_t.size() != 6) begin failures++; $display("FAIL stream_accepts got=%0d want=6", acc_t.size()); end
    for (int n = 1; n < acc_t.size(); n++) begin
      checks++;
      if (acc_t[n] - acc_t[n-1] != 20) begin
        failures++;
        $display("FAIL stream_chip_rate n=%0d got=%0d want=20", n, acc_t[n] - acc_t[n-1]);
      end
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.chip_ready !== 1'b1) begin
      failures++;
      $display("FAIL stream_idle valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.chip_ready);
    end
  endtask

  task automatic test_underflow();
    feed = '{1, 0, 2, 1};
    run_feed(130);
    exp_i.delete();
    exp_q.delete();
    for (int n = 0; n < 21; n++) begin
      int eq;
      eq = 0;
      if (n >= 4 && n < 12) eq = -PULSE[n-4];
      if (n >= 12 && n < 20) eq = PULSE[n-12];
      exp_i.push_back((n < 8) ? PULSE[n] : 0);
      exp_q.push_back(eq);
    end
    checks++;
    if (got_i.size() != 21) begin failures++; $display("FAIL underflow_count got=%0d want=21", got_i.size()); end
    for (int n = 0; n < 21; n++) begin
      checks++;
      if (n >= got_i.size() || int'(got_i[n]) !== exp_i[n] || int'(got_q[n]) !== exp_q[n]) begin
        failures++;
        $display("FAIL underflow_sample n=%0d got I=%0d Q=%0d want I=%0d Q=%0d", n, got_i[n], got_q[n], exp_i[n], exp_q[n]);
      end
    end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.chip_ready !== 1'b1) begin
      failures++;
      $display("FAIL underflow_idle valid=%b ready=%b want valid=0 ready=1", bus.out_valid, bus.chip_ready);
    end
  endtask

  task automatic test_reset_mid_burst();
    int  seen;
    bit  hit;
    seen = 0;
    hit  = 1'b0;
    @(negedge clk);
    bus.chip_valid = 1'b1;
    bus.chip_in    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.chip_valid = 1'b0;
    bus.chip_in    = 1'b0;
    for (int c = 0; c < 40 && !hit; c++) begin
      if (bus.out_valid === 1'b1) begin
        if (seen == 3) begin
          hit = 1'b1;
          checks++;
          if (bus.i_out !== 5'sd14) begin failures++; $display("FAIL midrst_pre got=%0d want=14", bus.i_out); end
        end
        seen++;
      end
      if (!hit) @(negedge clk);
    end
    checks++;
    if (!hit) begin failures++; $display("FAIL midrst_timeout got samples=%0d want=4", seen); end
    resetn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.i_out !== 5'sd0 || bus.q_out !== 5'sd0 || bus.out_valid !== 1'b0 || bus.chip_ready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_state got I=%0d Q=%0d valid=%b ready=%b want 0 0 0 1",
               bus.i_out, bus.q_out, bus.out_valid, bus.chip_ready);
    end
    resetn = 1'b1;
    feed = '{1};
    run_feed(70);
    checks++;
    if (got_i.size() != 9) begin failures++; $display("FAIL midrst_count got=%0d want=9", got_i.size()); end
    for (int n = 0; n < 9; n++) begin
      int ei;
      ei = (n < 8) ? PULSE[n] : 0;
      checks++;
      if (n >= got_i.size() || int'(got_i[n]) !== ei || int'(got_q[n]) !== 0) begin
        failures++;
        $display("FAIL midrst_sample n=%0d got I=%0d Q=%0d want I=%0d Q=0", n, got_i[n], got_q[n], ei);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_single_chip();
    test_back_to_back();
    test_stream();
    test_underflow();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
